// File: rtl/mem_readback_streamer.sv
// mem_readback_streamer: sweeps a contiguous address range through a block-RAM
// registered read port (1-cycle latency) and returns each word on a valid/ready
// stream, buffered by a 3-entry FIFO so reads stay ahead of a stalled consumer.
//
// Ports:
//   clk, reset             single clock, synchronous active-high reset
//   start, base_addr,      transfer request (sampled in IDLE only), first address,
//   word_count             number of words
//   mem_raddr, mem_rdata   registered read address out, read data in (1-cycle latency)
//   m_valid, m_ready,      output stream; m_last marks the word_count-th word
//   m_data, m_last
//   busy, done, err_range  transfer in progress, completion pulse, rejected-start pulse
//   checksum               running XOR of delivered words when READBACK_CHECKSUM_EN
//                          is defined, otherwise constant 0
//
// Optional feature macro: READBACK_CHECKSUM_EN

module mem_readback_streamer #(
  parameter int WID_MEM   = 32,
  parameter int DEPTH_MEM = 1024
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        base_addr,
  input  logic [31:0]        word_count,
  output logic [31:0]        mem_raddr,
  input  logic [WID_MEM-1:0] mem_rdata,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WID_MEM-1:0] m_data,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               err_range,
  output logic [WID_MEM-1:0] checksum
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t state, state_nxt;

  logic [31:0]        remaining;
  logic               inflight;
  logic               inflight_last;
  logic [WID_MEM-1:0] fifo_data [3];
  logic [2:0]         fifo_last;
  logic [1:0]         wr_ptr;
  logic [1:0]         rd_ptr;
  logic [1:0]         fifo_count;

  logic [32:0] range_end;
  logic        range_bad;
  logic [2:0]  occupancy;
  logic        accept;
  logic        reject;
  logic        issue;
  logic        push;
  logic        pop;

  // 33-bit sum so base_addr + word_count cannot wrap past the memory end.
  always_comb begin
    range_end = {1'b0, base_addr} + {1'b0, word_count};
    range_bad = (range_end > 33'(DEPTH_MEM)) ||
                ((base_addr >= 32'(DEPTH_MEM)) && (word_count != '0));
  end

  // Occupancy uses registered state only, so m_ready never reaches mem_raddr
  // combinationally. Steady state (1 buffered + 1 in flight) still issues every cycle.
  assign occupancy = {1'b0, fifo_count} + {2'b00, inflight};

  assign m_valid = (fifo_count != 2'd0);
  assign m_data  = fifo_data[rd_ptr];
  assign m_last  = fifo_last[rd_ptr];
  assign pop     = m_valid && m_ready;
  assign push    = inflight;
  assign busy    = (state == ISSUE) || (state == DRAIN);
  assign done    = (state == FINISH);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    reject    = 1'b0;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (range_bad) begin
            reject = 1'b1;
          end else begin
            accept    = 1'b1;
            state_nxt = (word_count == '0) ? FINISH : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (occupancy < 3'd3) begin
          issue = 1'b1;
          if (remaining == 32'd1) begin
            state_nxt = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && m_last) begin
          state_nxt = FINISH;
        end
      end
      FINISH: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_raddr     <= '0;
      remaining     <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_count    <= '0;
      fifo_last     <= '0;
      err_range     <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        fifo_data[i] <= '0;
      end
    end else begin
      err_range <= reject;

      if (accept && (word_count != '0)) begin
        mem_raddr <= base_addr;
        remaining <= word_count;
      end else if (issue) begin
        mem_raddr <= mem_raddr + 32'd1;
        remaining <= remaining - 32'd1;
      end

      // The last-word tag travels with the read so it lands beside its data.
      inflight      <= issue;
      inflight_last <= issue && (remaining == 32'd1);

      if (push) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_last[wr_ptr] <= inflight_last;
        wr_ptr            <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 2'd1;
        2'b01:   fifo_count <= fifo_count - 2'd1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

`ifdef READBACK_CHECKSUM_EN
  // Accept happens only in IDLE where the FIFO is empty, so clear and pop never collide.
  always_ff @(posedge clk) begin
    if (reset) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= '0;
    end else if (pop) begin
      checksum <= checksum ^ m_data;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
